cnoc_axi_ram: RTL and testbench

CNOC_AXI_RAM -- requirements
Module: cnoc_axi_ram

---
 rtl/cnoc_axi_ram.sv | 266 ++++++++++++++++++++++++++
 tb/tb_cnoc_axi_ram.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnoc_axi_ram.sv
// cnoc_axi_ram: AXI4 memory slave with independent read/write burst FSMs on a DEPTH-row RAM.
// Optional CNOC_AXI_RAM_BACKDOOR_EN adds read_mem/write_mem zero-time byte access.
package cnoc_pkg;
    localparam int CNOC_DATAW = 32;
    localparam int CNOC_ADDRW = 32;
    localparam int AXI_IDW    = 4;

    typedef struct packed {
        logic [AXI_IDW-1:0]    id;
        logic [CNOC_ADDRW-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } cnoc_ax_s;

    typedef struct packed {
        logic [CNOC_DATAW-1:0]   data;
        logic [CNOC_DATAW/8-1:0] strb;
        logic                    last;
    } cnoc_w_s;

    typedef struct packed {
        logic [AXI_IDW-1:0] id;
        logic [1:0]         resp;
        logic               user;
    } cnoc_b_s;

    typedef struct packed {
        logic [AXI_IDW-1:0]    id;
        logic [CNOC_DATAW-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic                  user;
    } cnoc_r_s;

    typedef struct packed {
        logic     aw_valid;
        cnoc_ax_s aw;
        logic     w_valid;
        cnoc_w_s  w;
        logic     b_ready;
        logic     ar_valid;
        cnoc_ax_s ar;
        logic     r_ready;
    } cnoc_req_s;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        logic    b_valid;
        cnoc_b_s b;
        logic    ar_ready;
        logic    r_valid;
        cnoc_r_s r;
    } cnoc_resp_s;
endpackage

module cnoc_axi_ram #(
    parameter int DATA_WIDTH = cnoc_pkg::CNOC_DATAW,
    parameter int ADDR_WIDTH = cnoc_pkg::CNOC_ADDRW,
    parameter int ID_WIDTH   = cnoc_pkg::AXI_IDW,
    parameter int DEPTH      = 1024
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  cnoc_pkg::cnoc_req_s  req,
    output cnoc_pkg::cnoc_resp_s resp
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int RW = $clog2(DEPTH);
    localparam logic [2:0] MAX_SIZE = 3'(LB);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    function automatic logic bad_burst(input logic [1:0] burst, input logic [7:0] len, input logic [2:0] size);
        return burst == 2'b11 || (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) || size > MAX_SIZE;
    endfunction

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1:LB] >= (ADDR_WIDTH-LB)'(DEPTH);
    endfunction

    function automatic logic [RW-1:0] row_of(input logic [ADDR_WIDTH-1:0] a);
        return RW'(a[ADDR_WIDTH-1:LB]);
    endfunction

    // WRAP keeps the bits above the (len+1)*2^size window and wraps the incremented offset inside it
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] size,
                                                        input logic [7:0] len, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] step, inc, wsz;
        step = ADDR_WIDTH'(1) << size;
        inc  = (a & ~(step - 1)) + step;
        wsz  = (ADDR_WIDTH'(len) + 1) << size;
        return burst == 2'b00 ? a : burst == 2'b10 ? ((a & ~(wsz - 1)) | (inc & (wsz - 1))) : inc;
    endfunction

    function automatic logic [DATA_WIDTH+1:0] fetch(input logic [ADDR_WIDTH-1:0] a, input logic ill);
        return (ill || out_of_range(a)) ? {2'b10, {DATA_WIDTH{1'b0}}} : {2'b00, mem[row_of(a)]};
    endfunction

    w_state_e              w_state;
    logic                  aw_rdy, w_rdy, b_valid, w_ill, w_err;
    logic [1:0]            b_resp, w_burst;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr, w_nxt;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic                  w_oor, w_beat_err, w_en;

    assign w_nxt      = next_addr(w_addr, w_size, w_len, w_burst);
    assign w_oor      = out_of_range(w_addr);
    assign w_beat_err = w_err || w_oor || (req.w.last != (w_cnt == w_len));
    assign w_en       = w_rdy && req.w_valid && !w_oor && !w_ill;

    always_ff @(posedge clk)
        if (w_en)
            for (int i = 0; i < NB; i++)
                if (req.w.strb[i]) mem[row_of(w_addr)][8*i +: 8] <= req.w.data[8*i +: 8];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            w_state <= W_IDLE;
            aw_rdy  <= 1'b0;
            w_rdy   <= 1'b0;
            b_valid <= 1'b0;
            b_resp  <= 2'b00;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_ill   <= 1'b0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE:
                    if (aw_rdy && req.aw_valid) begin
                        w_id    <= req.aw.id;
                        w_addr  <= req.aw.addr;
                        w_len   <= req.aw.len;
                        w_size  <= req.aw.size;
                        w_burst <= req.aw.burst;
                        w_ill   <= bad_burst(req.aw.burst, req.aw.len, req.aw.size);
                        w_err   <= bad_burst(req.aw.burst, req.aw.len, req.aw.size);
                        w_cnt   <= '0;
                        aw_rdy  <= 1'b0;
                        w_rdy   <= 1'b1;
                        w_state <= W_DATA;
                    end else aw_rdy <= 1'b1;
                W_DATA:
                    if (req.w_valid) begin
                        if (w_cnt == w_len) begin
                            w_rdy   <= 1'b0;
                            b_valid <= 1'b1;
                            b_resp  <= w_beat_err ? 2'b10 : 2'b00;
                            w_state <= W_RESP;
                        end else begin
                            w_cnt  <= w_cnt + 8'd1;
                            w_addr <= w_nxt;
                            w_err  <= w_beat_err;
                        end
                    end
                W_RESP:
                    if (req.b_ready) begin
                        b_valid <= 1'b0;
                        aw_rdy  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    r_state_e              r_state;
    logic                  ar_rdy, r_valid, r_last, r_ill;
    logic [1:0]            r_resp, r_burst;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_addr, r_nxt;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;

    assign r_nxt = next_addr(r_addr, r_size, r_len, r_burst);

    // Beat data is registered from the array on the accepting edge, so a same-edge write is seen next time
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= R_IDLE;
            ar_rdy  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ill   <= 1'b0;
            r_resp  <= 2'b00;
            r_data  <= '0;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                R_IDLE:
                    if (ar_rdy && req.ar_valid) begin
                        r_id             <= req.ar.id;
                        r_addr           <= req.ar.addr;
                        r_len            <= req.ar.len;
                        r_size           <= req.ar.size;
                        r_burst          <= req.ar.burst;
                        r_ill            <= bad_burst(req.ar.burst, req.ar.len, req.ar.size);
                        {r_resp, r_data} <= fetch(req.ar.addr, bad_burst(req.ar.burst, req.ar.len, req.ar.size));
                        r_last           <= req.ar.len == 8'd0;
                        r_cnt            <= '0;
                        r_valid          <= 1'b1;
                        ar_rdy           <= 1'b0;
                        r_state          <= R_DATA;
                    end else ar_rdy <= 1'b1;
                R_DATA:
                    if (req.r_ready) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            ar_rdy  <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt            <= r_cnt + 8'd1;
                            r_addr           <= r_nxt;
                            {r_resp, r_data} <= fetch(r_nxt, r_ill);
                            r_last           <= (r_cnt + 8'd1) == r_len;
                        end
                    end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        resp          = '0;
        resp.aw_ready = aw_rdy;
        resp.w_ready  = w_rdy;
        resp.b_valid  = b_valid;
        resp.b.id     = w_id;
        resp.b.resp   = b_resp;
        resp.ar_ready = ar_rdy;
        resp.r_valid  = r_valid;
        resp.r.id     = r_id;
        resp.r.data   = r_data;
        resp.r.resp   = r_resp;
        resp.r.last   = r_last;
    end

`ifdef CNOC_AXI_RAM_BACKDOOR_EN
    function automatic logic [7:0] read_mem(input int row, input int elem);
        return mem[RW'(row)][DATA_WIDTH-1-8*elem -: 8];
    endfunction

    function automatic void write_mem(input int row, input int elem, input logic [7:0] data);
        mem[RW'(row)][DATA_WIDTH-1-8*elem -: 8] = data;
    endfunction
`else
`endif
endmodule

// File: tb/tb_cnoc_axi_ram.sv
// tb_cnoc_axi_ram: directed-vector bench for cnoc_axi_ram (32-bit data, 1024 rows).
module tb_cnoc_axi_ram;
    import cnoc_pkg::*;
    localparam int DEPTH = 1024;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    cnoc_req_s  req;
    cnoc_resp_s resp;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic [31:0] d;
    logic [1:0]  rs;
    logic [3:0]  id;
    logic        lst;
    logic [31:0] wrap_exp [4];

    always #5 clk = ~clk;

    cnoc_axi_ram #(.DEPTH(DEPTH)) dut (.clk(clk), .arst_n(arst_n), .req(req), .resp(resp));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic aw_go(input logic [3:0] i, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        req.aw.id = i; req.aw.addr = a; req.aw.len = len; req.aw.size = size; req.aw.burst = burst;
        req.aw_valid = 1'b1;
        while (!resp.aw_ready && n < 50) begin tick; n++; end
        if (n >= 50) chk("aw_timeout", 0, 1);
        tick;
        req.aw_valid = 1'b0;
    endtask

    task automatic ar_go(input logic [3:0] i, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        req.ar.id = i; req.ar.addr = a; req.ar.len = len; req.ar.size = size; req.ar.burst = burst;
        req.ar_valid = 1'b1;
        while (!resp.ar_ready && n < 50) begin tick; n++; end
        if (n >= 50) chk("ar_timeout", 0, 1);
        tick;
        req.ar_valid = 1'b0;
    endtask

    task automatic w_go(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        req.w.data = data; req.w.strb = strb; req.w.last = last;
        req.w_valid = 1'b1;
        while (!resp.w_ready && n < 50) begin tick; n++; end
        if (n >= 50) chk("w_timeout", 0, 1);
        tick;
        req.w_valid = 1'b0;
    endtask

    task automatic b_take(output logic [3:0] bid, output logic [1:0] bresp);
        int n = 0;
        req.b_ready = 1'b1;
        while (!resp.b_valid && n < 50) begin tick; n++; end
        if (n >= 50) chk("b_timeout", 0, 1);
        bid = resp.b.id;
        bresp = resp.b.resp;
        tick;
        req.b_ready = 1'b0;
    endtask

    task automatic r_take(output logic [31:0] data, output logic [1:0] rresp, output logic last, output logic [3:0] rid);
        int n = 0;
        req.r_ready = 1'b1;
        while (!resp.r_valid && n < 50) begin tick; n++; end
        if (n >= 50) chk("r_timeout", 0, 1);
        data = resp.r.data; rresp = resp.r.resp; last = resp.r.last; rid = resp.r.id;
        tick;
        req.r_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req = '0;
        wrap_exp = '{32'h33, 32'h44, 32'h11, 32'h22};
        repeat (3) tick;
        chk("rst_aw_ready", resp.aw_ready, 0);
        chk("rst_ar_ready", resp.ar_ready, 0);
        chk("rst_b_valid", resp.b_valid, 0);
        chk("rst_r_valid", resp.r_valid, 0);
        arst_n = 1'b1;
        tick;
        chk("rel_aw_ready", resp.aw_ready, 1);
        chk("rel_ar_ready", resp.ar_ready, 1);

        // INCR write then read back at 0x40
        aw_go(4'd3, 32'h40, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) w_go(32'h11 * (i + 1), 4'hF, i == 3);
        b_take(id, rs);
        chk("incr_b_id", id, 3);
        chk("incr_b_resp", rs, 0);
        ar_go(4'd5, 32'h40, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            r_take(d, rs, lst, id);
            chk("incr_r_data", d, 32'h11 * (i + 1));
            chk("incr_r_last", lst, i == 3);
            chk("incr_r_resp", rs, 0);
            chk("incr_r_id", id, 5);
        end

        // WRAP from row 18 of the 16..19 block
        ar_go(4'd1, 32'h48, 8'd3, 3'd2, 2'b10);
        for (int i = 0; i < 4; i++) begin
            r_take(d, rs, lst, id);
            chk("wrap_r_data", d, wrap_exp[i]);
            chk("wrap_r_last", lst, i == 3);
        end

        // WRAP with len=2 is illegal: all three beats SLVERR with zero data
        ar_go(4'd2, 32'h40, 8'd2, 3'd2, 2'b10);
        for (int i = 0; i < 3; i++) begin
            r_take(d, rs, lst, id);
            chk("ill_r_resp", rs, 2);
            chk("ill_r_data", d, 0);
            chk("ill_r_last", lst, i == 2);
        end

        aw_go(4'd7, 32'h0, 8'd0, 3'd2, 2'b11);
        w_go(32'hDEAD, 4'hF, 1'b1);
        b_take(id, rs);
        chk("ill_b_resp", rs, 2);
        chk("ill_b_id", id, 7);

        // Out-of-range row DEPTH vs last legal row
        aw_go(4'd1, (DEPTH - 1) * 4, 8'd0, 3'd2, 2'b01);
        w_go(32'h12345678, 4'hF, 1'b1);
        b_take(id, rs);
        chk("edge_b_resp", rs, 0);
        aw_go(4'd2, DEPTH * 4, 8'd0, 3'd2, 2'b01);
        w_go(32'hFF, 4'hF, 1'b1);
        b_take(id, rs);
        chk("oor_b_resp", rs, 2);
        ar_go(4'd3, DEPTH * 4, 8'd0, 3'd2, 2'b01);
        r_take(d, rs, lst, id);
        chk("oor_r_data", d, 0);
        chk("oor_r_resp", rs, 2);
        ar_go(4'd3, (DEPTH - 1) * 4, 8'd0, 3'd2, 2'b01);
        r_take(d, rs, lst, id);
        chk("edge_r_data", d, 32'h12345678);

        // len=7 read with r_ready pattern 1,0,0,1,0,0,...
        aw_go(4'd4, 32'h80, 8'd7, 3'd2, 2'b01);
        for (int i = 0; i < 8; i++) w_go(32'h100 + i, 4'hF, i == 7);
        b_take(id, rs);
        chk("stall_b_resp", rs, 0);
        ar_go(4'd4, 32'h80, 8'd7, 3'd2, 2'b01);
        begin
            int beat = 0;
            int k = 0;
            while (beat < 8 && k < 100) begin
                req.r_ready = (k % 3 == 0);
                if (resp.r_valid) begin
                    chk("stall_r_data", resp.r.data, 32'h100 + beat);
                    if (req.r_ready) begin
                        chk("stall_r_last", resp.r.last, beat == 7);
                        beat++;
                    end
                end
                tick;
                k++;
            end
            req.r_ready = 1'b0;
            chk("stall_beats", beat, 8);
            chk("stall_done", resp.r_valid, 0);
        end

        // Same-edge read and write of row 5
        aw_go(4'd0, 32'h14, 8'd0, 3'd2, 2'b01);
        w_go(32'hAA, 4'hF, 1'b1);
        b_take(id, rs);
        aw_go(4'd0, 32'h14, 8'd0, 3'd2, 2'b01);
        req.w.data = 32'hBB; req.w.strb = 4'hF; req.w.last = 1'b1; req.w_valid = 1'b1;
        req.ar.id = 4'd9; req.ar.addr = 32'h14; req.ar.len = 8'd0; req.ar.size = 3'd2; req.ar.burst = 2'b01;
        req.ar_valid = 1'b1;
        chk("rbw_readies", {resp.w_ready, resp.ar_ready}, 2'b11);
        tick;
        req.w_valid = 1'b0;
        req.ar_valid = 1'b0;
        r_take(d, rs, lst, id);
        chk("rbw_old_data", d, 32'hAA);
        b_take(id, rs);
        chk("rbw_b_resp", rs, 0);
        ar_go(4'd0, 32'h14, 8'd0, 3'd2, 2'b01);
        r_take(d, rs, lst, id);
        chk("rbw_new_data", d, 32'hBB);

        // Reset pulse in the middle of a len=3 write
        aw_go(4'd6, 32'h200, 8'd3, 3'd2, 2'b01);
        w_go(32'h1, 4'hF, 1'b0);
        w_go(32'h2, 4'hF, 1'b0);
        #2 arst_n = 1'b0;
        #1;
        chk("mid_rst_aw_ready", resp.aw_ready, 0);
        chk("mid_rst_w_ready", resp.w_ready, 0);
        chk("mid_rst_b_valid", resp.b_valid, 0);
        repeat (2) tick;
        arst_n = 1'b1;
        tick;
        chk("post_rst_aw_ready", resp.aw_ready, 1);
        chk("post_rst_w_ready", resp.w_ready, 0);
        begin
            logic seen = 1'b0;
            req.b_ready = 1'b1;
            repeat (5) begin
                if (resp.b_valid) seen = 1'b1;
                tick;
            end
            req.b_ready = 1'b0;
            chk("post_rst_no_b", seen, 0);
        end

`ifdef CNOC_AXI_RAM_BACKDOOR_EN
        dut.write_mem(7, 0, 8'h5A);
        ar_go(4'd0, 32'h1C, 8'd0, 3'd2, 2'b01);
        r_take(d, rs, lst, id);
        chk("backdoor_msb", d[31:24], 8'h5A);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
